fetch_seq_ctrl: RTL and testbench

//  Parametrised fetch/sequencing controller for the 9-bit-ISA core: owns the program counter,
//  a run-time writable branch-target table, the registered ALU flags (parity, zero, shift/carry)
//  and a req/done run-control FSM with cycle counter and watchdog. Sits between Control/ALU and

---
 rtl/fetch_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch/sequencing controller: PC, branch-target table, ALU flags, run FSM
// Replaces the discrete PC, fixed PC_LUT and flag registers of the 9-bit-ISA core.
module fetch_seq_ctrl #(
    parameter int unsigned D          = 12,
    parameter int unsigned LUT_AW     = 6,
    parameter int unsigned START_PC   = 0,
    parameter int unsigned DONE_PC    = 128,
    parameter int unsigned CW         = 16,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    input  logic              absjump_en,
    input  logic              reljump_en,
    input  logic [1:0]        br_cond,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              pari_in,
    input  logic              zero_in,
    input  logic              sc_in,
    input  logic              flag_en,
    input  logic              sc_clr,
    input  logic              sc_en,
    output logic [D-1:0]      prog_ctr,
    output logic              pc_valid,
    output logic              pariQ,
    output logic              zeroQ,
    output logic              scQ,
    output logic              done,
    output logic              timeout,
    output logic [CW-1:0]     cycles
);

    localparam int unsigned   TAB_N   = 2 ** LUT_AW;
    localparam logic [D-1:0]  START_V = START_PC[D-1:0];
    localparam logic [D-1:0]  DONE_V  = DONE_PC[D-1:0];
    localparam logic [CW-1:0] MAX_V   = MAX_CYCLES[CW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          pari_q, pari_d;
    logic          zero_q, zero_d;
    logic          sc_q, sc_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [D-1:0]  tab_q [TAB_N];

    logic          at_done_pc;
    logic          wd_hit;
    logic          cond_ok;
    logic          taken;
    logic [D-1:0]  target;
    logic [D-1:0]  next_pc;

    assign at_done_pc = (pc_q == DONE_V);
    assign wd_hit     = (MAX_CYCLES != 0) && (cycles_q == MAX_V);
    assign target     = tab_q[lut_idx];

    always_comb begin
        cond_ok = 1'b1;
        case (br_cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = zero_q;
            2'b10:   cond_ok = ~zero_q;
            default: cond_ok = sc_q;
        endcase
    end

    assign taken = (absjump_en | reljump_en) & cond_ok;

    // Absolute jump wins when both jump kinds are requested; PC arithmetic wraps mod 2**D.
    always_comb begin
        next_pc = pc_q + D'(1);
        if (taken) begin
            if (absjump_en) begin
                next_pc = target;
            end else begin
                next_pc = pc_q + target;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cycles_d  = cycles_q;
        pari_d    = pari_q;
        zero_d    = zero_q;
        sc_d      = sc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d   = ST_RUN;
                    pc_d      = START_V;
                    cycles_d  = '0;
                    pari_d    = 1'b0;
                    zero_d    = 1'b0;
                    sc_d      = 1'b0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (at_done_pc) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (wd_hit) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    pc_d = next_pc;
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + CW'(1);
                    end
                    if (flag_en) begin
                        pari_d = pari_in;
                        zero_d = zero_in;
                    end
                    if (sc_clr) begin
                        sc_d = 1'b0;
                    end else if (sc_en) begin
                        sc_d = sc_in;
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_V;
            cycles_q  <= '0;
            pari_q    <= 1'b0;
            zero_q    <= 1'b0;
            sc_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cycles_q  <= cycles_d;
            pari_q    <= pari_d;
            zero_q    <= zero_d;
            sc_q      <= sc_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Table writes are accepted in every state; a same-cycle read still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAB_N; i++) begin
                tab_q[i] <= '0;
            end
        end else if (lut_we) begin
            tab_q[lut_waddr] <= lut_wdata;
        end
    end

    assign prog_ctr = pc_q;
    assign pc_valid = (state_q == ST_RUN) & ~at_done_pc & ~wd_hit;
    assign pariQ    = pari_q;
    assign zeroQ    = zero_q;
    assign scQ      = sc_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - randomized bench for fetch_seq_ctrl against a behavioural model
module tb_fetch_seq_ctrl;

    localparam int D      = 12;
    localparam int AW     = 6;
    localparam int CW     = 16;
    localparam int PC_MOD = 4096;
    localparam int CYCMAX = 65535;

    logic          clk = 1'b0;
    logic          reset;
    logic          req, lut_we, absjump_en, reljump_en;
    logic [AW-1:0] lut_waddr, lut_idx;
    logic [D-1:0]  lut_wdata;
    logic [1:0]    br_cond;
    logic          pari_in, zero_in, sc_in, flag_en, sc_clr, sc_en;

    logic [D-1:0]  a_prog_ctr, b_prog_ctr;
    logic          a_pc_valid, a_pariQ, a_zeroQ, a_scQ, a_done, a_timeout;
    logic          b_pc_valid, b_pariQ, b_zeroQ, b_scQ, b_done, b_timeout;
    logic [CW-1:0] a_cycles, b_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // model: index 0 = default instance (no watchdog), 1 = watchdog at 50
    int maxc [2] = '{0, 50};
    int m_state [2];   // 0 idle, 1 run, 2 done
    int m_pc [2];
    int m_cyc [2];
    int m_p [2];
    int m_z [2];
    int m_sc [2];
    int m_done [2];
    int m_to [2];
    int m_tab [64];

    always #5 clk = ~clk;

    fetch_seq_ctrl dut_a (
        .clk(clk), .reset(reset), .req(req), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .absjump_en(absjump_en), .reljump_en(reljump_en),
        .br_cond(br_cond), .lut_idx(lut_idx), .pari_in(pari_in), .zero_in(zero_in),
        .sc_in(sc_in), .flag_en(flag_en), .sc_clr(sc_clr), .sc_en(sc_en),
        .prog_ctr(a_prog_ctr), .pc_valid(a_pc_valid), .pariQ(a_pariQ), .zeroQ(a_zeroQ),
        .scQ(a_scQ), .done(a_done), .timeout(a_timeout), .cycles(a_cycles)
    );

    fetch_seq_ctrl #(.MAX_CYCLES(50)) dut_b (
        .clk(clk), .reset(reset), .req(req), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .absjump_en(absjump_en), .reljump_en(reljump_en),
        .br_cond(br_cond), .lut_idx(lut_idx), .pari_in(pari_in), .zero_in(zero_in),
        .sc_in(sc_in), .flag_en(flag_en), .sc_clr(sc_clr), .sc_en(sc_en),
        .prog_ctr(b_prog_ctr), .pc_valid(b_pc_valid), .pariQ(b_pariQ), .zeroQ(b_zeroQ),
        .scQ(b_scQ), .done(b_done), .timeout(b_timeout), .cycles(b_cycles)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_valid(input int k);
        return (m_state[k] == 1 && m_pc[k] != 128 && !(maxc[k] != 0 && m_cyc[k] == maxc[k])) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_pc[k] = 0; m_cyc[k] = 0; m_p[k] = 0;
            m_z[k] = 0; m_sc[k] = 0; m_done[k] = 0; m_to[k] = 0;
        end
        for (int i = 0; i < 64; i++) m_tab[i] = 0;
    endtask

    task automatic model_step();
        int cond, tgt;
        for (int k = 0; k < 2; k++) begin
            case (m_state[k])
                0: if (req) begin
                    m_state[k] = 1; m_pc[k] = 0; m_cyc[k] = 0;
                    m_p[k] = 0; m_z[k] = 0; m_sc[k] = 0; m_done[k] = 0; m_to[k] = 0;
                end
                1: if (m_pc[k] == 128) begin
                    m_state[k] = 2; m_done[k] = 1; m_to[k] = 0;
                end else if (maxc[k] != 0 && m_cyc[k] == maxc[k]) begin
                    m_state[k] = 2; m_done[k] = 1; m_to[k] = 1;
                end else begin
                    case (br_cond)
                        2'd0: cond = 1;
                        2'd1: cond = m_z[k];
                        2'd2: cond = 1 - m_z[k];
                        default: cond = m_sc[k];
                    endcase
                    tgt = m_tab[lut_idx];
                    if ((absjump_en || reljump_en) && cond != 0) begin
                        if (absjump_en) m_pc[k] = tgt;
                        else m_pc[k] = (m_pc[k] + tgt) % PC_MOD;
                    end else begin
                        m_pc[k] = (m_pc[k] + 1) % PC_MOD;
                    end
                    if (m_cyc[k] < CYCMAX) m_cyc[k]++;
                    if (flag_en) begin m_p[k] = pari_in; m_z[k] = zero_in; end
                    if (sc_clr) m_sc[k] = 0;
                    else if (sc_en) m_sc[k] = sc_in;
                end
                default: if (!req) begin m_state[k] = 0; m_done[k] = 0; end
            endcase
        end
        if (lut_we) m_tab[lut_waddr] = lut_wdata;
    endtask

    task automatic check_all();
        check_val("a.pc", int'(a_prog_ctr), m_pc[0]);
        check_val("a.valid", int'(a_pc_valid), model_valid(0));
        check_val("a.pari", int'(a_pariQ), m_p[0]);
        check_val("a.zero", int'(a_zeroQ), m_z[0]);
        check_val("a.sc", int'(a_scQ), m_sc[0]);
        check_val("a.done", int'(a_done), m_done[0]);
        check_val("a.timeout", int'(a_timeout), m_to[0]);
        check_val("a.cycles", int'(a_cycles), m_cyc[0]);
        check_val("b.pc", int'(b_prog_ctr), m_pc[1]);
        check_val("b.valid", int'(b_pc_valid), model_valid(1));
        check_val("b.pari", int'(b_pariQ), m_p[1]);
        check_val("b.zero", int'(b_zeroQ), m_z[1]);
        check_val("b.sc", int'(b_scQ), m_sc[1]);
        check_val("b.done", int'(b_done), m_done[1]);
        check_val("b.timeout", int'(b_timeout), m_to[1]);
        check_val("b.cycles", int'(b_cycles), m_cyc[1]);
    endtask

    // called at a falling edge with inputs already driven
    task automatic step();
        check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        lut_we = 0; lut_waddr = '0; lut_wdata = '0; absjump_en = 0; reljump_en = 0;
        br_cond = 2'd0; lut_idx = '0; pari_in = 0; zero_in = 0; sc_in = 0;
        flag_en = 0; sc_clr = 0; sc_en = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic write_tab(input int idx, input int val);
        lut_we = 1; lut_waddr = AW'(idx); lut_wdata = D'(val);
        step();
        lut_we = 0;
    endtask

    task automatic run_until_pc(input int k, input int pc);
        int n = 0;
        while (m_pc[k] != pc && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) check_val("run_until_pc_bound", m_pc[k], pc);
    endtask

    initial begin
        int n;
        req = 0;
        clear_inputs();
        reset = 1;
        #1;
        model_reset();
        check_all();
        check_val("rst_pc", int'(a_prog_ctr), 0);
        check_val("rst_valid", int'(a_pc_valid), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 0;

        // straight-line run to DONE_PC; instance b times out at 50
        req = 1;
        step();
        req = 0;
        check_val("t1_valid", int'(a_pc_valid), 1);
        check_val("t1_pc0", int'(a_prog_ctr), 0);
        run_until_pc(0, 128);
        check_val("t1_pc128", int'(a_prog_ctr), 128);
        check_val("t1_valid128", int'(a_pc_valid), 0);
        check_val("t1_cycles", int'(a_cycles), 128);
        check_val("t1_b_pc", int'(b_prog_ctr), 50);
        check_val("t1_b_timeout", int'(b_timeout), 1);
        step();
        check_val("t1_done", int'(a_done), 1);
        check_val("t1_timeout", int'(a_timeout), 0);

        // absolute and relative jumps
        apply_reset();
        write_tab(5, 40);
        write_tab(2, 12'hFFC);
        write_tab(3, 20);
        req = 1;
        step();
        run_until_pc(0, 3);
        absjump_en = 1; br_cond = 2'd0; lut_idx = 6'd5;
        step();
        check_val("t2_abs", int'(a_prog_ctr), 40);
        reljump_en = 1;
        step();
        check_val("t2_abs_rel", int'(a_prog_ctr), 40);
        reljump_en = 0; lut_idx = 6'd3; flag_en = 1; zero_in = 1;
        step();
        check_val("t3_pc20", int'(a_prog_ctr), 20);
        check_val("t3_zero1", int'(a_zeroQ), 1);
        absjump_en = 0; reljump_en = 1; br_cond = 2'd1; lut_idx = 6'd2; flag_en = 0;
        step();
        check_val("t3_rel_taken", int'(a_prog_ctr), 16);
        absjump_en = 1; reljump_en = 0; br_cond = 2'd0; lut_idx = 6'd3; flag_en = 1; zero_in = 0;
        step();
        absjump_en = 0; reljump_en = 1; br_cond = 2'd1; lut_idx = 6'd2; flag_en = 0;
        step();
        check_val("t3_rel_not_taken", int'(a_prog_ctr), 21);
        clear_inputs();

        // watchdog on a tight loop at PC 10
        apply_reset();
        write_tab(0, 10);
        req = 1;
        step();
        flag_en = 1; pari_in = 1;
        step();
        flag_en = 0; pari_in = 0;
        n = 0;
        while (m_done[1] == 0 && n < 200) begin
            absjump_en = (m_pc[1] == 10); lut_idx = 6'd0;
            step();
            n++;
        end
        absjump_en = 0;
        check_val("t4_done", int'(b_done), 1);
        check_val("t4_timeout", int'(b_timeout), 1);
        check_val("t4_cycles", int'(b_cycles), 50);
        check_val("t4_pc", int'(b_prog_ctr), 10);
        check_val("t4_pari_held", int'(b_pariQ), 1);

        // req handshake in DONE
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t5_done_hold", int'(b_done), 1);
        end
        req = 0;
        step();
        check_val("t5_done_drop", int'(b_done), 0);
        req = 1;
        step();
        check_val("t5_restart_pc", int'(b_prog_ctr), 0);
        check_val("t5_restart_cycles", int'(b_cycles), 0);
        check_val("t5_restart_pari", int'(b_pariQ), 0);
        check_val("t5_restart_timeout", int'(b_timeout), 0);

        // sc_clr priority, then async reset mid-run
        apply_reset();
        req = 1;
        step();
        req = 0; sc_en = 1; sc_in = 1;
        step();
        check_val("t6_sc_set", int'(a_scQ), 1);
        sc_clr = 1;
        step();
        check_val("t6_sc_clr", int'(a_scQ), 0);
        clear_inputs();
        run_until_pc(0, 37);
        check_val("t6_pc37", int'(a_prog_ctr), 37);
        reset = 1;
        #1;
        check_val("t6_async_pc", int'(a_prog_ctr), 0);
        check_val("t6_async_done", int'(a_done), 0);
        check_val("t6_async_valid", int'(a_pc_valid), 0);
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                req        = ($urandom_range(0, 3) != 0);
                lut_we     = ($urandom_range(0, 3) == 0);
                lut_waddr  = AW'($urandom);
                lut_wdata  = D'($urandom);
                absjump_en = ($urandom_range(0, 5) == 0);
                reljump_en = ($urandom_range(0, 5) == 0);
                br_cond    = 2'($urandom);
                lut_idx    = AW'($urandom);
                pari_in    = 1'($urandom);
                zero_in    = 1'($urandom);
                sc_in      = 1'($urandom);
                flag_en    = 1'($urandom);
                sc_clr     = ($urandom_range(0, 3) == 0);
                sc_en      = 1'($urandom);
                step();
            end
        end
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
